// File: rtl/next_pc_gen.sv
// next_pc_gen: next-PC generation at the head of the fetch pipeline.
//
// Picks this cycle's fetch PC (recovery > rename > fetch-stage taken
// prediction > held PC), drives the I-cache read address and the per-slot
// valid mask, advances a debug serial ID, and optionally runs a wait FSM
// that requests bubbles a fixed delay after a misprediction.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall, clear        controller stall / invalidate current group
//   intr_valid/intr_pc  interrupt redirect (enters via the PC register)
//   recov_valid/recov_pc, ren_valid/ren_pc  same-cycle redirects
//   mispred             execute-stage misprediction (wait FSM trigger)
//   fetch_valid/taken/target/pc0  fetch-stage prediction feedback
//   np_pc, np_valid     selected PC and slot valid mask
//   ic_addr             I-cache read address
//   send_bubble         bubble request from the wait FSM
//   sid                 serial ID of slot 0
module next_pc_gen #(
    parameter int               FETCH_WIDTH     = 4,
    parameter int               PC_WIDTH        = 32,
    parameter int               INSN_BYTES      = 4,
    parameter int               LINE_BYTES      = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = 32'h0000_1000,
    parameter bit               STOP_ON_MISPRED = 1'b0,
    parameter int               WAIT_DELAY      = 2,
    parameter int               SID_WIDTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          clear,
    input  logic                          intr_valid,
    input  logic [PC_WIDTH-1:0]           intr_pc,
    input  logic                          recov_valid,
    input  logic [PC_WIDTH-1:0]           recov_pc,
    input  logic                          ren_valid,
    input  logic [PC_WIDTH-1:0]           ren_pc,
    input  logic                          mispred,
    input  logic [FETCH_WIDTH-1:0]        fetch_valid,
    input  logic [FETCH_WIDTH-1:0]        fetch_taken,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] fetch_target,
    input  logic [PC_WIDTH-1:0]           fetch_pc0,
    output logic [PC_WIDTH-1:0]           np_pc,
    output logic [FETCH_WIDTH-1:0]        np_valid,
    output logic [PC_WIDTH-1:0]           ic_addr,
    output logic                          send_bubble,
    output logic [SID_WIDTH-1:0]          sid
);

    localparam int GROUP_BYTES = FETCH_WIDTH * INSN_BYTES;
    localparam int CNT_W       = $clog2(FETCH_WIDTH + 1);

    logic [PC_WIDTH-1:0]    pcReg;
    logic [PC_WIDTH-1:0]    pcNext;
    logic                   pcWe;
    logic                   regStall;
    logic                   beginStall;
    logic [FETCH_WIDTH-1:0] takenVec;
    logic                   predUsed;
    logic [PC_WIDTH-1:0]    predPc;
    logic [PC_WIDTH-1:0]    lineOff;
    logic [PC_WIDTH-1:0]    lineRoom;
    logic [PC_WIDTH-1:0]    step;
    logic [CNT_W-1:0]       leadOnes;
    logic [SID_WIDTH-1:0]   sidReg;

    assign beginStall = stall & ~regStall;
    assign takenVec   = fetch_valid & fetch_taken;
    // Predictions are only trusted on the first cycle of a stall or when not
    // stalled; while stalled the fetch stage is replaying stale data.
    assign predUsed   = ~regStall & (|takenVec);

    // Lowest taken slot wins: scan from the top so lower slots overwrite.
    always_comb begin
        predPc = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (takenVec[i]) begin
                predPc = fetch_target[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    always_comb begin
        if (recov_valid)   np_pc = recov_pc;
        else if (ren_valid) np_pc = ren_pc;
        else if (predUsed)  np_pc = predPc;
        else                np_pc = pcReg;
    end

    // A fetch group never crosses a cache line: step only to the line end.
    assign lineOff  = np_pc & PC_WIDTH'(LINE_BYTES - 1);
    assign lineRoom = PC_WIDTH'(LINE_BYTES) - lineOff;
    assign step     = (lineRoom < PC_WIDTH'(GROUP_BYTES)) ? lineRoom : PC_WIDTH'(GROUP_BYTES);

    always_comb begin
        if (intr_valid)      pcNext = intr_pc;
        else if (beginStall) pcNext = np_pc;
        else                 pcNext = np_pc + step;
    end

    assign pcWe = intr_valid | recov_valid | ren_valid | predUsed | ~stall | beginStall;

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : gen_slot_valid
            assign np_valid[gi] = ~intr_valid & ~clear &
                ((lineOff + PC_WIDTH'(gi * INSN_BYTES)) < PC_WIDTH'(LINE_BYTES));
        end
    endgenerate

    always_comb begin
        logic run;
        run      = 1'b1;
        leadOnes = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            run = run & np_valid[i];
            if (run) leadOnes = leadOnes + CNT_W'(1);
        end
    end

    assign ic_addr = (stall & fetch_valid[0]) ? fetch_pc0 : np_pc;
    assign sid     = sidReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcReg    <= RESET_PC;
            regStall <= 1'b0;
            sidReg   <= SID_WIDTH'(1);
        end else begin
            regStall <= stall;
            if (pcWe) pcReg <= pcNext;
            if (~stall & ~clear) sidReg <= sidReg + SID_WIDTH'(leadOnes);
        end
    end

    typedef enum logic {PH_FETCH, PH_WAIT} phaseType;

    generate
        if (STOP_ON_MISPRED) begin : gen_wait_fsm
            phaseType   phaseReg, phaseNext;
            logic [3:0] waitCntReg, waitCntNext;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    phaseReg   <= PH_FETCH;
                    waitCntReg <= 4'd0;
                end else begin
                    phaseReg   <= phaseNext;
                    waitCntReg <= waitCntNext;
                end
            end

            always_comb begin
                phaseNext   = phaseReg;
                waitCntNext = waitCntReg;
                case (phaseReg)
                    PH_FETCH: begin
                        if (mispred & ~recov_valid) begin
                            phaseNext   = PH_WAIT;
                            waitCntNext = 4'd0;
                        end
                    end
                    PH_WAIT: begin
                        // Further mispredicts are ignored until recovery.
                        if (recov_valid) begin
                            phaseNext = PH_FETCH;
                        end else if (waitCntReg != 4'(WAIT_DELAY)) begin
                            waitCntNext = waitCntReg + 4'd1;
                        end
                    end
                    default: phaseNext = PH_FETCH;
                endcase
            end

            assign send_bubble = (phaseReg == PH_WAIT) &
                                 (waitCntReg == 4'(WAIT_DELAY)) & ~recov_valid;
        end else begin : gen_no_wait_fsm
            logic unusedMispred;
            assign unusedMispred = mispred;
            assign send_bubble   = 1'b0;
        end
    endgenerate

endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
- Parametrised next-PC generation stage at the head of the fetch pipeline.
- Selects this cycle's fetch PC from interrupt, backend recovery, rename recovery, fetch-stage taken predictions and sequential increment.
- Drives the I-cache read address and per-slot valid mask, and keeps a debug serial-ID counter.
- Adds a configurable stop-fetch-on-mispredict mode: a wait-state FSM with a programmable bubble delay.

Parameters:
- FETCH_WIDTH, 4, instruction slots per fetch group (power of 2, 1..8).
- PC_WIDTH, 32, PC / address width.
- INSN_BYTES, 4, bytes per instruction slot.
- LINE_BYTES, 64, I-cache line size (power of 2, >= FETCH_WIDTH*INSN_BYTES).
- RESET_PC, 32'h0000_1000, PC after reset.
- STOP_ON_MISPRED, 0, 1 enables the fetch-wait FSM.
- WAIT_DELAY, 2, cycles in WAIT before bubbles are requested (1..15).
- SID_WIDTH, 16, debug serial-ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall from controller
- clear  in  1  invalidate this cycle's group
- intr_valid  in  1  interrupt redirect
- intr_pc  in  PC_WIDTH  interrupt target
- recov_valid  in  1  recovery from RW/commit
- recov_pc  in  PC_WIDTH  recovery target
- ren_valid  in  1  redirect from rename
- ren_pc  in  PC_WIDTH  rename redirect target
- mispred  in  1  execute-stage misprediction detected
- fetch_valid  in  FETCH_WIDTH  fetch-stage slot valid
- fetch_taken  in  FETCH_WIDTH  fetch-stage slot predicted taken
- fetch_target  in  FETCH_WIDTH*PC_WIDTH  predicted target per slot (slot i at [i*PC_WIDTH +: PC_WIDTH])
- fetch_pc0  in  PC_WIDTH  PC of fetch-stage slot 0
- np_pc  out  PC_WIDTH  selected PC this cycle
- np_valid  out  FETCH_WIDTH  slot valid mask
- ic_addr  out  PC_WIDTH  I-cache read address
- send_bubble  out  1  request bubble insertion
- sid  out  SID_WIDTH  serial ID of slot 0

Behaviour:
- Reset (rst=0, async):
  - pc_q=RESET_PC, reg_stall=0, sid=1, phase=FETCH, wait_cnt=0.
  - Outputs then follow from these values combinationally: np_pc=RESET_PC, send_bubble=0.
- reg_stall <= stall every cycle.
- begin_stall = stall & ~reg_stall.
- np_pc selection, combinational, same-cycle, strict priority:
  1. recov_valid: recov_pc
  2. ren_valid: ren_pc
  3. ~reg_stall: fetch_target of the lowest slot i with fetch_valid[i] & fetch_taken[i]
  4. otherwise: pc_q
- step: min(FETCH_WIDTH*INSN_BYTES, LINE_BYTES - (np_pc mod LINE_BYTES)). Arithmetic modulo 2^PC_WIDTH.
- pc_q next value:
  - intr_valid: intr_pc (interrupt enters via pc_q, not np_pc; one-cycle latency).
  - else begin_stall: np_pc.
  - else: np_pc + step.
- pc_q write enable: intr_valid | recov_valid | ren_valid | any taken prediction used | ~stall | begin_stall.
- np_valid[i]=1 iff all of:
  - ~intr_valid
  - ~clear
  - np_pc + i*INSN_BYTES lies in the same cache line as np_pc
- ic_addr: fetch_pc0 when stall & fetch_valid[0], else np_pc.
- sid:
  - Adds the count of leading ones of np_valid when ~stall & ~clear.
  - Holds otherwise.
  - Wraps at 2^SID_WIDTH.
- Wait FSM (STOP_ON_MISPRED=1; when 0, send_bubble is tied to 0 and the FSM is absent):
  - FETCH -> WAIT on mispred & ~recov_valid; wait_cnt <= 0.
  - WAIT: wait_cnt saturates at WAIT_DELAY.
  - WAIT -> FETCH on recov_valid. recov_valid has priority over mispred in the same cycle.
  - send_bubble = (phase==WAIT) & (wait_cnt==WAIT_DELAY) & ~recov_valid.
  - mispred while already in WAIT: ignored.

Test Plan:
1. Release reset, no stall, no redirects -> np_pc 0x1000, 0x1010, 0x1020; np_valid=4'b1111; sid 1, 5, 9.
2. Force pc_q=0x1038 (redirect via ren_pc=0x1038) -> np_valid=4'b0011, next np_pc=0x1040, sid advances by 2.
3. fetch_valid=4'b1111, fetch_taken=4'b0110, slot1 target 0x2000 -> np_pc=0x2000 same cycle; with reg_stall=1 the prediction is ignored.
4. recov_valid (0x3000), ren_valid (0x4000) and intr_valid (0x5000) in the same cycle -> np_pc=0x3000, np_valid=0; next cycle np_pc=0x5000.
5. stall rises at np_pc=0x1100 with fetch_valid[0]=1, fetch_pc0=0x10F0 -> ic_addr=0x10F0; pc_q=0x1100 held through the stall; sid frozen.
6. STOP_ON_MISPRED=1, WAIT_DELAY=2: mispred pulse -> send_bubble=1 from the 3rd cycle after the pulse; recov_valid -> send_bubble=0 that cycle, phase FETCH. Async reset mid-WAIT -> send_bubble=0 immediately.
